// File: rtl/dist_presence_ctrl.sv
// dist_presence_ctrl
//   Consumes completed distance measurements from the ranging stage, smooths
//   them with a 4-sample moving average and runs a hysteresis presence FSM
//   with an away-hold timer that drives the fan enable.
//
// Ports
//   clk        system clock, posedge
//   reset_p    asynchronous active-high reset
//   distance   raw distance in cm (12 bit)
//   dist_valid one-cycle strobe, distance is complete
//   dist_avg   smoothed distance in cm
//   avg_valid  one-cycle pulse when dist_avg updates
//   present    person detected (S_PRESENT)
//   fan_en     fan on (S_PRESENT or S_LEAVING)
//   state      one-hot {S_LEAVING, S_PRESENT, S_ABSENT}
module dist_presence_ctrl #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int NEAR_CM    = 50,
  parameter int FAR_CM     = 80,
  parameter int MAX_CM     = 400,
  parameter int HOLD_MS    = 3000,
  parameter int MISS_LIMIT = 5
) (
  input  logic        clk,
  input  logic        reset_p,
  input  logic [11:0] distance,
  input  logic        dist_valid,
  output logic [11:0] dist_avg,
  output logic        avg_valid,
  output logic        present,
  output logic        fan_en,
  output logic [2:0]  state
);

  localparam int TICK_DIV = CLK_HZ / 1000;
  localparam int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int MW       = $clog2(MISS_LIMIT + 1);

  typedef enum logic [2:0] {
    S_ABSENT  = 3'b001,
    S_PRESENT = 3'b010,
    S_LEAVING = 3'b100
  } state_t;

  state_t st, st_nx;

  // Sample classification
  logic sample_ok, sample_bad;
  assign sample_ok  = dist_valid && (distance != 12'd0) && (distance <= 12'(MAX_CM));
  assign sample_bad = dist_valid && !sample_ok;

  // Averaging buffer: [0] newest, [3] oldest
  logic [3:0][11:0] sbuf;
  logic [13:0]      sum;
  logic             primed;
  // vld_pipe[0]: sum updated last edge; vld_pipe[1]: dist_avg updated last edge
  logic [1:0]       vld_pipe;

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      sbuf     <= '0;
      sum      <= '0;
      primed   <= 1'b0;
      vld_pipe <= '0;
      dist_avg <= '0;
    end else begin
      vld_pipe <= {vld_pipe[0], sample_ok};
      if (sample_ok) begin
        if (!primed) begin
          // First sample fills the whole window so the average starts at the
          // measured value instead of ramping up from zero.
          sbuf   <= {4{distance}};
          sum    <= {distance, 2'b00};
          primed <= 1'b1;
        end else begin
          sbuf <= {sbuf[2:0], distance};
          sum  <= sum + {2'b00, distance} - {2'b00, sbuf[3]};
        end
      end
      if (vld_pipe[0]) dist_avg <= sum[13:2];
    end
  end

  assign avg_valid = vld_pipe[1];

  // Consecutive invalid sample counter, saturating
  logic [MW-1:0] miss_cnt;

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p)                                     miss_cnt <= '0;
    else if (sample_ok)                              miss_cnt <= '0;
    else if (sample_bad && miss_cnt != MW'(MISS_LIMIT)) miss_cnt <= miss_cnt + 1'b1;
  end

  // ms prescaler and hold timer only run while leaving; holding them at zero
  // elsewhere clears both on every entry to S_LEAVING.
  logic [PW-1:0] presc;
  logic [15:0]   hold_ms;
  logic          tick;

  assign tick = (st == S_LEAVING) && (presc == PW'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      presc   <= '0;
      hold_ms <= '0;
    end else if (st != S_LEAVING) begin
      presc   <= '0;
      hold_ms <= '0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick) hold_ms <= hold_ms + 16'd1;
    end
  end

  // FSM: state register
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) st <= S_ABSENT;
    else         st <= st_nx;
  end

  logic near, far, miss_hit, hold_done;
  assign near      = avg_valid && (dist_avg <= 12'(NEAR_CM));
  assign far       = avg_valid && (dist_avg >  12'(FAR_CM));
  assign miss_hit  = (miss_cnt == MW'(MISS_LIMIT));
  assign hold_done = tick && (hold_ms == 16'(HOLD_MS - 1));

  // FSM: next state
  always_comb begin
    st_nx = st;
    unique case (st)
      S_ABSENT:  if (near) st_nx = S_PRESENT;
      S_PRESENT: if (far || miss_hit) st_nx = S_LEAVING;
      S_LEAVING: begin
        // A near reading beats a coincident hold expiry.
        if (near)           st_nx = S_PRESENT;
        else if (hold_done) st_nx = S_ABSENT;
      end
      default:   st_nx = S_ABSENT;
    endcase
  end

  // FSM: outputs
  always_comb begin
    present = (st == S_PRESENT);
    fan_en  = (st == S_PRESENT) || (st == S_LEAVING);
    state   = st;
  end

endmodule

// File: tb/tb_dist_presence_ctrl.sv
module tb_dist_presence_ctrl;

  logic        clk = 1'b0;
  logic        reset_p;
  logic [11:0] distance;
  logic        dist_valid;
  logic [11:0] dist_avg;
  logic        avg_valid;
  logic        present;
  logic        fan_en;
  logic [2:0]  state;

  dist_presence_ctrl #(.CLK_HZ(10_000), .HOLD_MS(4)) dut (
    .clk(clk), .reset_p(reset_p), .distance(distance), .dist_valid(dist_valid),
    .dist_avg(dist_avg), .avg_valid(avg_valid), .present(present),
    .fan_en(fan_en), .state(state)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int n_pulse = 0;
  int expq[$];

  // reference window: mb[0] newest
  int mb[4];
  bit mprimed;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) mb[i] = 0;
    mprimed = 0;
    expq.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // One-cycle strobe; consecutive calls give back-to-back strobes.
  task automatic strobe(input int d);
    distance   = 12'(d);
    dist_valid = 1'b1;
    if (d != 0 && d <= 400) begin
      if (!mprimed) begin
        for (int i = 0; i < 4; i++) mb[i] = d;
        mprimed = 1;
      end else begin
        for (int i = 3; i > 0; i--) mb[i] = mb[i-1];
        mb[0] = d;
      end
      expq.push_back((mb[0] + mb[1] + mb[2] + mb[3]) / 4);
    end
    @(posedge clk); #1;
    dist_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset_p = 1'b1; dist_valid = 1'b0; distance = '0;
    model_clear();
    idle(2);
    reset_p = 1'b0;
  endtask

  task automatic chk_state(input string tag, input int exp);
    chk(tag, int'(state), exp);
  endtask

  // scoreboard consumer
  always @(negedge clk) begin
    if (!reset_p && avg_valid) begin
      n_pulse++;
      if (expq.size() == 0) chk("avg_unexpected", int'(avg_valid), 0);
      else chk("avg", int'(dist_avg), expq.pop_front());
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int c0;
    reset_p = 1'b0; dist_valid = 1'b0; distance = '0;
    model_clear();
    #1;
    do_reset();

    // reset state
    chk("rst_avg", int'(dist_avg), 0);
    chk("rst_avgv", int'(avg_valid), 0);
    chk("rst_present", int'(present), 0);
    chk("rst_fan", int'(fan_en), 0);
    chk_state("rst_state", 1);

    // first sample primes; latency E+1 for avg, E+2 for state
    strobe(30);
    chk("lat_e0_avgv", int'(avg_valid), 0);
    idle(1);
    chk("lat_e1_avgv", int'(avg_valid), 1);
    chk("lat_e1_avg", int'(dist_avg), 30);
    chk_state("lat_e1_state", 1);
    idle(1);
    chk("lat_e2_avgv", int'(avg_valid), 0);
    chk_state("lat_e2_state", 2);
    chk("lat_e2_present", int'(present), 1);
    chk("lat_e2_fan", int'(fan_en), 1);

    // averaging 100 -> 85,70,55 (absent), 40 (present)
    do_reset();
    strobe(100); idle(3); chk_state("avg100", 1);
    strobe(40);  idle(3); chk_state("avg85", 1);
    strobe(40);  idle(3); chk_state("avg70", 1);
    strobe(40);  idle(3); chk_state("avg55", 1);
    chk("avg55_val", int'(dist_avg), 55);
    strobe(40);  idle(3); chk_state("avg40", 2);

    // leave, then cancel before the hold expires
    strobe(200); idle(3); chk_state("hb_80", 2);
    strobe(200); idle(3); chk_state("hb_120", 4);
    chk("leave_fan", int'(fan_en), 1);
    chk("leave_present", int'(present), 0);
    strobe(200); idle(3);
    strobe(10);  idle(3);
    strobe(10);  idle(3);
    strobe(10);  idle(3); chk_state("cancel_57", 4);
    strobe(10);  idle(3); chk_state("cancel_10", 2);

    // leave and let the hold expire on the 4th tick (40 cycles)
    strobe(200); idle(3);
    strobe(200); idle(2);
    chk_state("hold_entry", 4);
    idle(39);
    chk_state("hold_39", 4);
    idle(1);
    chk_state("hold_40", 1);
    chk("hold_fan", int'(fan_en), 0);

    // invalid samples: 5 zeros
    do_reset();
    strobe(20); idle(3); chk_state("inv_pre", 2);
    c0 = n_pulse;
    for (int i = 0; i < 4; i++) begin strobe(0); idle(1); end
    chk_state("inv_4", 2);
    strobe(0); idle(1);
    chk_state("inv_5", 4);
    chk("inv_avg", int'(dist_avg), 20);
    chk("inv_pulses", n_pulse - c0, 0);

    // 4 zeros then an out-of-range sample
    strobe(20); idle(3); chk_state("inv2_pre", 2);
    for (int i = 0; i < 4; i++) begin strobe(0); idle(1); end
    strobe(500); idle(1);
    chk_state("inv2_500", 4);

    // an interleaved valid sample restarts the count
    strobe(20); idle(3); chk_state("inv3_pre", 2);
    for (int i = 0; i < 3; i++) begin strobe(0); idle(1); end
    strobe(20); idle(3);
    for (int i = 0; i < 4; i++) begin strobe(0); idle(1); end
    idle(2);
    chk_state("inv3_held", 2);
    strobe(0); idle(1);
    chk_state("inv3_5", 4);

    // back-to-back out-of-range, then back-to-back max
    do_reset();
    c0 = n_pulse;
    for (int i = 0; i < 4; i++) strobe(4095);
    idle(3);
    chk("b2b_bad_pulses", n_pulse - c0, 0);
    chk("b2b_bad_avg", int'(dist_avg), 0);
    chk_state("b2b_bad_state", 1);
    c0 = n_pulse;
    for (int i = 0; i < 4; i++) strobe(400);
    idle(3);
    chk("b2b_pulses", n_pulse - c0, 4);
    chk("b2b_avg", int'(dist_avg), 400);

    // async reset mid-hold
    do_reset();
    strobe(20);  idle(3);
    strobe(300); idle(3);
    chk_state("ar_leaving", 4);
    idle(15);
    #2;
    reset_p = 1'b1;
    #1;
    chk("ar_avg", int'(dist_avg), 0);
    chk("ar_fan", int'(fan_en), 0);
    chk("ar_present", int'(present), 0);
    chk_state("ar_state", 1);
    model_clear();
    idle(1);
    reset_p = 1'b0;
    strobe(60); idle(3);
    chk("ar_reprime", int'(dist_avg), 60);
    chk_state("ar_reprime_state", 1);

    chk("queue_drained", expq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
